// File: rtl/alu_flag_branch_unit.sv
// alu_flag_branch_unit
// Buffers ALU results in a 2-entry in-order writeback FIFO, tracks the
// committed {carry, zero, sign} flags, and resolves conditional branches
// against those flags with a two-state branch FSM.
module alu_flag_branch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [3:0]  res_op,
    input  logic [31:0] res_data,
    input  logic        res_carry,
    input  logic        res_zero,
    input  logic        res_sign,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [2:0]  flags,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [31:0] br_target,
    output logic        branch_done,
    output logic        take_branch,
    output logic [31:0] branch_pc,
    output logic        err_op
);

    typedef enum logic {
        B_IDLE,
        B_RESOLVE
    } bstate_t;

    bstate_t     state;
    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        carry_q;
    logic        zero_q;
    logic        sign_q;
    logic [2:0]  cond_q;
    logic [31:0] target_q;
    logic        res_acc;
    logic        res_legal;
    logic        push;
    logic        pop;
    logic        cond_met;

    // Handshakes and FIFO head; ready outputs are forced low while reset is held
    always_comb begin
        res_ready = reset & (count != 2'd2);
        wb_valid  = (count != 2'd0);
        wb_data   = wb_valid ? mem[rd_ptr] : '0;
        res_acc   = res_valid & res_ready;
        res_legal = (res_op <= 4'd8);
        push      = res_acc & res_legal;
        pop       = wb_valid & wb_ready;
    end

    // Writeback FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Committed flags; carry only follows add and 2's complement; illegal ops flag err_op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            err_op  <= 1'b0;
        end else begin
            err_op <= res_acc & ~res_legal;
            if (push) begin
                zero_q <= res_zero;
                sign_q <= res_sign;
                if (res_op == 4'd0 || res_op == 4'd3) begin
                    carry_q <= res_carry;
                end
            end
        end
    end

    // Branch FSM: latch the request, resolve one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= B_IDLE;
            cond_q   <= '0;
            target_q <= '0;
        end else begin
            case (state)
                B_IDLE: begin
                    if (br_valid) begin
                        cond_q   <= br_cond;
                        target_q <= br_target;
                        state    <= B_RESOLVE;
                    end
                end
                default: begin
                    state <= B_IDLE;
                end
            endcase
        end
    end

    // Decision reads the flag registers during B_RESOLVE, which already hold
    // any update from a result accepted alongside the branch request
    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = zero_q;
            3'b010:  cond_met = ~zero_q;
            3'b011:  cond_met = carry_q;
            3'b100:  cond_met = ~carry_q;
            3'b101:  cond_met = sign_q;
            3'b110:  cond_met = ~sign_q;
            default: cond_met = 1'b0;
        endcase
        br_ready    = reset & (state == B_IDLE);
        branch_done = (state == B_RESOLVE);
        take_branch = branch_done & cond_met;
        branch_pc   = branch_done ? target_q : '0;
        flags       = {carry_q, zero_q, sign_q};
    end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Testbench for alu_flag_branch_unit: directed scenarios followed by random
// traffic, checked by a queue-based scoreboard fed from a reference model.
module tb_alu_flag_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [3:0]  res_op = '0;
    logic [31:0] res_data = '0;
    logic        res_carry = 1'b0;
    logic        res_zero = 1'b0;
    logic        res_sign = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [2:0]  flags;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  br_cond = '0;
    logic [31:0] br_target = '0;
    logic        branch_done;
    logic        take_branch;
    logic [31:0] branch_pc;
    logic        err_op;

    alu_flag_branch_unit dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .res_sign(res_sign),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .flags(flags),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_target(br_target),
        .branch_done(branch_done), .take_branch(take_branch),
        .branch_pc(branch_pc), .err_op(err_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_wb [$];
    logic [32:0] exp_br [$];
    int          m_cnt = 0;
    logic        m_c = 1'b0;
    logic        m_z = 1'b0;
    logic        m_s = 1'b0;
    logic        m_err = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_pop;
    logic        m_acc;
    logic [32:0] e_br;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic taken(input logic [2:0] c, input logic cy, input logic z, input logic s);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return cy;
            3'd4:    return !cy;
            3'd5:    return s;
            3'd6:    return !s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        exp_wb.delete();
        exp_br.delete();
        m_cnt  = 0;
        m_c    = 1'b0;
        m_z    = 1'b0;
        m_s    = 1'b0;
        m_err  = 1'b0;
        m_busy = 1'b0;
    endtask

    // Reference model: evaluates each clock edge from the inputs it saw
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                model_clear();
            end else begin
                m_pop = (m_cnt > 0) && wb_ready;
                m_acc = res_valid && (m_cnt < 2);
                m_err = m_acc && (res_op > 4'd8);
                if (m_acc && res_op <= 4'd8) begin
                    exp_wb.push_back(res_data);
                    m_z = res_zero;
                    m_s = res_sign;
                    if (res_op == 4'd0 || res_op == 4'd3) m_c = res_carry;
                    m_cnt++;
                end
                if (m_pop) m_cnt--;
                if (m_busy) begin
                    m_busy = 1'b0;
                end else if (br_valid) begin
                    exp_br.push_back({taken(br_cond, m_c, m_z, m_s), br_target});
                    m_busy = 1'b1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("res_ready", res_ready, m_cnt < 2);
                check("br_ready", br_ready, !m_busy);
                check("wb_valid", wb_valid, m_cnt != 0);
                check("flags", flags, {m_c, m_z, m_s});
                check("err_op", err_op, m_err);
                check("branch_done", branch_done, m_busy);
                if (wb_valid && wb_ready) begin
                    if (exp_wb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_pop: unexpected entry %0h, none expected", wb_data);
                    end else begin
                        check("wb_data", wb_data, exp_wb.pop_front());
                    end
                end
                if (branch_done) begin
                    if (exp_br.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL br_pop: unexpected branch pc %0h, none expected", branch_pc);
                    end else begin
                        e_br = exp_br.pop_front();
                        check("take_branch", take_branch, e_br[32]);
                        check("branch_pc", branch_pc, e_br[31:0]);
                    end
                end else begin
                    check("take_idle", take_branch, 0);
                    check("pc_idle", branch_pc, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic [3:0] op, input logic [31:0] d,
                           input logic c, input logic z, input logic s);
        res_valid = v;
        res_op    = op;
        res_data  = d;
        res_carry = c;
        res_zero  = z;
        res_sign  = s;
    endtask

    task automatic set_br(input logic v, input logic [2:0] c, input logic [31:0] t);
        br_valid  = v;
        br_cond   = c;
        br_target = t;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_res_ready", res_ready, 0);
        check("rst_br_ready", br_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_flags", flags, 0);
        check("rst_done", branch_done, 0);
        check("rst_err", err_op, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_res_ready", res_ready, 1);
        check("post_rst_br_ready", br_ready, 1);

        // add with carry and zero
        set_res(1'b1, 4'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("d1_flags", flags, 3'b110);
        check("d1_wb_valid", wb_valid, 1);
        check("d1_wb_data", wb_data, 0);

        // bcy then bncy
        tick();
        set_br(1'b1, 3'b011, 32'h40);
        tick();
        set_br(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        check("d2_done", branch_done, 1);
        check("d2_take", take_branch, 1);
        check("d2_pc", branch_pc, 32'h40);
        tick();
        set_br(1'b1, 3'b100, 32'h44);
        tick();
        set_br(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        check("d2_done_b", branch_done, 1);
        check("d2_take_b", take_branch, 0);

        // carry kept by non-add op, then sign set
        tick();
        wb_ready = 1'b1;
        set_res(1'b1, 4'd1, 32'd104, 1'b0, 1'b0, 1'b0);
        tick();
        set_res(1'b1, 4'd7, 32'd1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("d3_flags_a", flags, 3'b100);
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("d3_flags_b", flags, 3'b101);

        // FIFO fill, backpressure, in-order drain
        tick();
        wb_ready = 1'b0;
        set_res(1'b1, 4'd1, 32'd105, 1'b0, 1'b0, 1'b0);
        tick();
        set_res(1'b1, 4'd1, 32'd215, 1'b0, 1'b0, 1'b0);
        tick();
        set_res(1'b1, 4'd1, 32'd20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("d4_full", res_ready, 0);
        check("d4_head", wb_data, 32'd105);
        tick();
        @(negedge clk);
        check("d4_held", res_ready, 0);
        tick();
        wb_ready = 1'b1;
        tick();
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // illegal op, then branch alongside a zero-setting result
        tick();
        set_res(1'b1, 4'b1010, 32'hdead, 1'b1, 1'b1, 1'b1);
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("d5_err", err_op, 1);
        check("d5_nopush", wb_valid, 0);
        check("d5_flags", flags, 3'b100);
        tick();
        @(negedge clk);
        check("d5_err_end", err_op, 0);
        tick();
        set_res(1'b1, 4'd0, 32'd7, 1'b0, 1'b1, 1'b0);
        set_br(1'b1, 3'b001, 32'h80);
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_br(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        check("d5_same_cycle_take", take_branch, 1);

        // reset during B_RESOLVE with a full FIFO
        tick();
        wb_ready = 1'b0;
        set_res(1'b1, 4'd0, 32'd11, 1'b1, 1'b0, 1'b1);
        tick();
        set_res(1'b1, 4'd0, 32'd22, 1'b1, 1'b0, 1'b1);
        set_br(1'b1, 3'b010, 32'h90);
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_br(1'b0, 3'b000, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("d6_done", branch_done, 0);
        check("d6_wb_valid", wb_valid, 0);
        check("d6_flags", flags, 0);
        check("d6_res_ready", res_ready, 0);
        check("d6_br_ready", br_ready, 0);
        check("d6_wb_data", wb_data, 0);
        model_clear();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("d6_res_ready_after", res_ready, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            set_res($urandom_range(0, 9) < 6,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                    $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            set_br(1'($urandom), 3'($urandom), $urandom);
            wb_ready = $urandom_range(0, 9) < 7;
        end
        tick();
        set_res(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_br(1'b0, 3'b000, 32'h0);
        wb_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("drain_wb", exp_wb.size(), 0);
        check("drain_br", exp_br.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_branch_unit.md
ALU_FLAG_BRANCH_UNIT -- requirements
Module: alu_flag_branch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, using the ports below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 res_valid  input  1  ALU result present on res_* this cycle.
REQ-005 res_ready  output  1  block can accept a result.
REQ-006 res_op  input  4  ALU operation code that produced the result.
REQ-007 res_data  input  32  ALU out.
REQ-008 res_carry / res_zero / res_sign  input  1 each  ALU flags.
REQ-009 wb_valid  output  1  writeback entry available.
REQ-010 wb_ready  input  1  writeback consumer accepts the entry.
REQ-011 wb_data  output  32  head writeback entry.
REQ-012 flags  output  3  committed flags {carry, zero, sign}.
REQ-013 br_valid  input  1  branch request.
REQ-014 br_ready  output  1  block can accept a branch request.
REQ-015 br_cond  input  3  condition: 000 always, 001 bz, 010 bnz, 011 bcy, 100 bncy, 101 bs, 110 bns, 111 reserved.
REQ-016 br_target  input  32  branch target address.
REQ-017 branch_done  output  1  one-cycle pulse; decision valid.
REQ-018 take_branch  output  1  branch taken; qualified by branch_done.
REQ-019 branch_pc  output  32  latched br_target; qualified by branch_done.
REQ-020 err_op  output  1  one-cycle pulse; illegal res_op dropped.

Function
REQ-021 Result accept = res_valid & res_ready; writeback pop = wb_valid & wb_ready.
REQ-022 Writeback buffer: 2-entry FIFO, in-order.
  - res_ready = not full.
  - wb_valid = count != 0.
  - wb_data = head entry.
REQ-023 Push and pop in the same cycle with count 1 SHALL leave count at 1, with the new entry at the head on the next cycle.
REQ-024 Pop at count 2 SHALL free one slot, so res_ready = 1 on the next cycle.
  - A pop with count 0 SHALL have no effect.
REQ-025 Legal res_op values are 0000–1000. For an accepted legal op:
  - res_data is pushed.
  - zero and sign are updated from res_zero / res_sign at the clock edge.
REQ-026 Carry SHALL update only for res_op 0000 (add) and 0011 (2's complement); all other legal ops SHALL keep carry.
REQ-027 An accepted res_op of 1001–1111 SHALL:
  - not push;
  - leave flags unchanged;
  - pulse err_op high for exactly the next cycle.
REQ-028 Branch FSM, two states.
  - B_IDLE: br_ready = 1. br_valid moves the FSM to B_RESOLVE and latches br_cond and br_target.
  - B_RESOLVE: br_ready = 0; branch_done = 1 for this single cycle; the FSM returns to B_IDLE on the next edge.
  - Latency: a request accepted in cycle N gives branch_done in cycle N+1. Maximum rate: one branch per 2 cycles.
REQ-029 The decision SHALL use the committed flags at the end of acceptance cycle N. This includes any flag update from a result accepted in cycle N.
  - A result accepted in cycle N+1 SHALL NOT affect the decision.
REQ-030 Taken rules:
  - 000: always taken.
  - 001: zero = 1.
  - 010: zero = 0.
  - 011: carry = 1.
  - 100: carry = 0.
  - 101: sign = 1.
  - 110: sign = 0.
  - 111: never taken.
REQ-031 branch_pc SHALL equal the latched br_target during branch_done; take_branch and branch_pc SHALL be 0 when branch_done = 0.
REQ-032 Result path and branch path SHALL operate independently in the same cycle.

Reset
REQ-033 While reset = 0, the following SHALL be 0: FIFO count, flags, take_branch, branch_pc, branch_done, err_op, wb_valid, wb_data, res_ready and br_ready. The FSM SHALL be in B_IDLE.
REQ-034 Reset asserted mid-operation SHALL clear all state immediately, discarding FIFO contents and any in-flight branch.
REQ-035 On the first edge after reset deasserts: res_ready = 1, br_ready = 1.

Verification
REQ-036 Result res_op=0000, data=0, carry=1, zero=1, sign=0 -> flags=3'b110, wb_data=0, wb_valid=1.
REQ-037 After REQ-036, br_cond=011, target=0x40 -> next cycle branch_done=1, take_branch=1, branch_pc=0x40.
  - Then br_cond=100 -> take_branch=0.
REQ-038 Sequence:
  - res_op=0001, data=104, carry=0, zero=0, sign=0 -> carry stays 1, flags=3'b100.
  - Then res_op=0111 with sign=1 (data=1) -> flags=3'b101.
REQ-039 wb_ready=0, push 105, 215, 20 -> res_ready=0 after the second push and the third is held.
  - Raise wb_ready -> pops 105, 215, 20 in order.
REQ-040 res_op=1010 -> err_op pulses 1 cycle, no push, flags unchanged.
  - Same-cycle br_valid (bz) and result with zero=1 -> take_branch=1.
REQ-041 Assert reset during B_RESOLVE with 2 entries buffered -> branch_done=0, wb_valid=0, flags=0 immediately.
